// File: rtl/result_serializer_if.sv
// rtl/result_serializer_if.sv - byte-stream valid/ready bundle between the result serializer and the output pins
interface result_serializer_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - captures the N_ELEM x ELEM_W result vector and streams it LSB-byte-first
// Optional trailing XOR checksum byte enabled by SERIALIZER_CHECKSUM_EN.
module result_serializer #(
    parameter int N_ELEM = 9,
    parameter int ELEM_W = 18,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_ELEM*ELEM_W-1:0] c_flat,
    output logic                     busy,
    output logic                     done,
    result_serializer_if.master      out_if
);
    localparam int BPE = (ELEM_W + OUT_W - 1) / OUT_W;
    localparam int EIW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int BIW = (BPE > 1) ? $clog2(BPE) : 1;

`ifdef SERIALIZER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM, S_FINISH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_FINISH} state_t;
`endif

    state_t                   state_q, state_d;
    logic [N_ELEM*ELEM_W-1:0] cap_q;
    logic [EIW-1:0]           elem_q, elem_nx;
    logic [BIW-1:0]           byte_q, byte_nx;
    logic [OUT_W-1:0]         data_q;
    logic                     out_valid;
    logic                     xfer;
    logic                     byte_wrap;
    logic                     last_byte;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [OUT_W-1:0]         csum_q;
`endif

    // Element is zero-extended to a whole number of bytes before the byte is picked.
    function automatic logic [OUT_W-1:0] pick_byte(input logic [N_ELEM*ELEM_W-1:0] vec,
                                                   input logic [EIW-1:0] e,
                                                   input logic [BIW-1:0] b);
        logic [BPE*OUT_W-1:0] padded;
        padded = '0;
        padded[ELEM_W-1:0] = vec[int'(e)*ELEM_W +: ELEM_W];
        return padded[int'(b)*OUT_W +: OUT_W];
    endfunction

`ifdef SERIALIZER_CHECKSUM_EN
    assign out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
`else
    assign out_valid = (state_q == S_SEND);
`endif
    assign xfer      = out_valid && out_if.out_ready;
    assign byte_wrap = (byte_q == BIW'(BPE - 1));
    assign last_byte = byte_wrap && (elem_q == EIW'(N_ELEM - 1));
    assign elem_nx   = byte_wrap ? elem_q + EIW'(1) : elem_q;
    assign byte_nx   = byte_wrap ? '0 : byte_q + BIW'(1);

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = out_valid;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SEND;
`ifdef SERIALIZER_CHECKSUM_EN
            S_SEND: if (xfer && last_byte) state_d = S_CSUM;
            S_CSUM: if (xfer) state_d = S_FINISH;
`else
            S_SEND: if (xfer && last_byte) state_d = S_FINISH;
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The next byte is prefetched into data_q on each transfer so the output stays registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            elem_q <= '0;
            byte_q <= '0;
            data_q <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cap_q  <= c_flat;
                        elem_q <= '0;
                        byte_q <= '0;
                        data_q <= pick_byte(c_flat, '0, '0);
`ifdef SERIALIZER_CHECKSUM_EN
                        csum_q <= '0;
`endif
                    end
                end
                S_SEND: begin
                    if (xfer) begin
`ifdef SERIALIZER_CHECKSUM_EN
                        csum_q <= csum_q ^ data_q;
`endif
                        if (last_byte) begin
`ifdef SERIALIZER_CHECKSUM_EN
                            data_q <= csum_q ^ data_q;
`endif
                        end else begin
                            elem_q <= elem_nx;
                            byte_q <= byte_nx;
                            data_q <= pick_byte(cap_q, elem_nx, byte_nx);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
